adder_test_driver: RTL and testbench
====================================

// Module: adder_test_driver
// PURPOSE
//  Initiator side of the instrumented adder test interface. Generates operand pairs from a
//  32-bit LFSR, launches one timed add per run and waits for the adder's done strobe.
//  Checks each returned sum against a locally computed reference and accumulates run/error
//  counts plus the latest ring-oscillator count for host readback over logic-analyser bits.
//  Sits between the LA host registers and the instrumented adder inside the wrapped project.
// PARAMETERS
//  WIDTH      32      operand/sum/count width
//  RUNS_W     16      width of run counter, error counter and num_runs
//  TIMEOUT    1024    wb_clk_i cycles to wait for adder_done before flagging a timeout
//  LFSR_TAPS  32'h80200003  Galois right-shift mask (x^32+x^22+x^2+x+1)
// PORTS
//  wb_clk_i      in   1       system clock, all logic on rising edge
//  wb_rst_i      in   1       asynchronous reset, active-high
//  go            in   1       rising edge in IDLE starts a batch
//  seed          in   WIDTH   LFSR seed, sampled on go; 0 is replaced by 1
//  num_runs      in   RUNS_W  runs per batch; 0 means 1
//  a_out         out  WIDTH   operand A to adder, held stable from LOAD to CHECK
//  b_out         out  WIDTH   operand B to adder
//  adder_start   out  1       one-cycle launch pulse
//  adder_done    in   1       one-cycle completion pulse from adder
//  adder_sum     in   WIDTH   adder result, valid when adder_done=1
//  adder_count   in   WIDTH   ring-oscillator count for the run, valid with adder_done
//  busy          out  1       high from go until DONE entered
//  batch_done    out  1       high in DONE until next go
//  run_count     out  RUNS_W  completed runs in current batch
//  err_count     out  RUNS_W  runs with sum mismatch or timeout, saturating
//  last_count    out  WIDTH   adder_count captured on most recent adder_done
//  timeout_flag  out  1       sticky per batch: any run timed out
// BEHAVIOUR
//  - Reset: state=IDLE; a_out,b_out,run_count,err_count,last_count=0; adder_start,busy,
//    batch_done,timeout_flag=0; lfsr=1. Reset mid-run aborts at once; no start issued after.
//  - go edge-detected (registered go_q); level held high does not retrigger.
//  - IDLE: on go rise -> LOAD; lfsr<=seed (or 1), clear counters and timeout_flag, busy=1,
//    batch_done=0. go ignored in every other state.
//  - LOAD (2 cycles): cycle 1 a_out<=lfsr, lfsr steps; cycle 2 b_out<=lfsr, lfsr steps.
//    Step: lsb=1 ? (s>>1)^LFSR_TAPS : s>>1.
//  - LAUNCH (1 cycle): adder_start=1, timer cleared, expected<=a_out+b_out mod 2^WIDTH -> WAIT.
//  - WAIT: timer increments. adder_done=1 -> last_count<=adder_count, mismatch if
//    adder_sum!=expected -> CHECK. timer==TIMEOUT-1 without done -> timeout_flag=1, mismatch=1 -> CHECK.
//    adder_done outside WAIT is ignored.
//  - CHECK (1 cycle): run_count+=1; err_count+=mismatch, saturating at all-ones;
//    run_count==num_runs-1 (pre-increment; num_runs 0 treated as 1) -> DONE, else LOAD.
//  - DONE: busy=0, batch_done=1; outputs hold; go rise -> LOAD as from IDLE.
//  - Per-run latency with done arriving k cycles after start: 2+1+k+1 cycles.
//  - adder_done in the same cycle as timeout expiry counts as done (no timeout).
// TESTING
//  - seed=1, num_runs=1, adder returns correct sum -> a_out=0x00000001, b_out=0x80200003,
//    one adder_start pulse, run_count=1, err_count=0, batch_done=1.
//  - seed=0 -> identical to seed=1 (a_out=0x00000001).
//  - num_runs=4, model adds +1 to sum on run 3 -> run_count=4, err_count=1.
//  - adder never responds, TIMEOUT=16, num_runs=2 -> timeout_flag=1, err_count=2, batch_done=1,
//    each WAIT lasting exactly 16 cycles.
//  - adder_count=0x12345678 returned with done -> last_count=0x12345678 next cycle.
//  - assert wb_rst_i during WAIT, deassert, hold go high -> stays IDLE, all outputs zero,
//    no adder_start until go falls and rises again.

Source files
------------

// File: rtl/adder_test_driver.sv
// adder_test_driver: LFSR-driven initiator that launches timed adds, checks sums and
// accumulates run/error/ring-oscillator counts for host readback.
module adder_test_driver #(
    parameter int WIDTH = 32,
    parameter int RUNS_W = 16,
    parameter int TIMEOUT = 1024,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 32'h80200003
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              go,
    input  logic [WIDTH-1:0]  seed,
    input  logic [RUNS_W-1:0] num_runs,
    output logic [WIDTH-1:0]  a_out,
    output logic [WIDTH-1:0]  b_out,
    output logic              adder_start,
    input  logic              adder_done,
    input  logic [WIDTH-1:0]  adder_sum,
    input  logic [WIDTH-1:0]  adder_count,
    output logic              busy,
    output logic              batch_done,
    output logic [RUNS_W-1:0] run_count,
    output logic [RUNS_W-1:0] err_count,
    output logic [WIDTH-1:0]  last_count,
    output logic              timeout_flag
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_LAUNCH, S_WAIT, S_CHECK, S_DONE} state_t;

    state_t state, next;
    logic go_q, mismatch;
    logic [WIDTH-1:0] lfsr, expected;
    logic [TW-1:0] timer;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
        return s[0] ? (s >> 1) ^ LFSR_TAPS : s >> 1;
    endfunction

    wire go_rise = go & ~go_q;
    wire timed_out = timer == TW'(TIMEOUT - 1);
    wire [RUNS_W-1:0] last_idx = (num_runs == '0) ? '0 : num_runs - 1'b1;

    assign adder_start = state == S_LAUNCH;
    assign busy = state != S_IDLE && state != S_DONE;
    assign batch_done = state == S_DONE;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) state <= S_IDLE;
        else state <= next;

    always_comb begin
        next = state;
        case (state)
            S_IDLE, S_DONE: next = go_rise ? S_LOAD_A : state;
            S_LOAD_A: next = S_LOAD_B;
            S_LOAD_B: next = S_LAUNCH;
            S_LAUNCH: next = S_WAIT;
            S_WAIT: next = (adder_done || timed_out) ? S_CHECK : S_WAIT;
            S_CHECK: next = (run_count == last_idx) ? S_DONE : S_LOAD_A;
            default: next = S_IDLE;
        endcase
    end

    // go_q resets high so a go level held through reset cannot look like a fresh edge
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            go_q <= 1'b1;
            lfsr <= WIDTH'(1);
            a_out <= '0;
            b_out <= '0;
            expected <= '0;
            timer <= '0;
            mismatch <= 1'b0;
            run_count <= '0;
            err_count <= '0;
            last_count <= '0;
            timeout_flag <= 1'b0;
        end else begin
            go_q <= go;
            case (state)
                S_IDLE, S_DONE: if (go_rise) begin
                    lfsr <= (seed == '0) ? WIDTH'(1) : seed;
                    run_count <= '0;
                    err_count <= '0;
                    timeout_flag <= 1'b0;
                end
                S_LOAD_A: begin
                    a_out <= lfsr;
                    lfsr <= step(lfsr);
                end
                S_LOAD_B: begin
                    b_out <= lfsr;
                    lfsr <= step(lfsr);
                end
                S_LAUNCH: begin
                    timer <= '0;
                    expected <= a_out + b_out;
                    mismatch <= 1'b0;
                end
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    if (adder_done) begin
                        last_count <= adder_count;
                        mismatch <= adder_sum != expected;
                    end else if (timed_out) begin
                        timeout_flag <= 1'b1;
                        mismatch <= 1'b1;
                    end
                end
                S_CHECK: begin
                    run_count <= run_count + 1'b1;
                    err_count <= (mismatch && !(&err_count)) ? err_count + 1'b1 : err_count;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_test_driver.sv
// tb_adder_test_driver: table-driven batches against a delay-programmable adder responder,
// plus hand sequences for last_count capture and reset during a run.
module tb_adder_test_driver;
    logic clk = 0, rst = 1, go = 0, adder_done, adder_start, busy, batch_done, timeout_flag;
    logic [31:0] seed = 0, a_out, b_out, adder_sum = 0, adder_count = 0, last_count, cnt_val = 0;
    logic [15:0] num_runs = 1, run_count, err_count;
    int tests = 0, fails = 0, delay = 1, nstarts, last_t, imin, imax, cnt, cyc;
    bit respond = 1, corrupt = 0, pending;
    logic [31:0] fa, fb;

    typedef struct {
        logic [31:0] seed;
        logic [15:0] n;
        int delay;
        bit resp;
        int bad;
        logic [15:0] er, ee;
        bit et;
        logic [31:0] ea, eb;
    } vec_t;
    vec_t v[7];

    adder_test_driver #(.WIDTH(32), .RUNS_W(16), .TIMEOUT(16), .LFSR_TAPS(32'h80200003)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .go(go), .seed(seed), .num_runs(num_runs),
        .a_out(a_out), .b_out(b_out), .adder_start(adder_start), .adder_done(adder_done),
        .adder_sum(adder_sum), .adder_count(adder_count), .busy(busy), .batch_done(batch_done),
        .run_count(run_count), .err_count(err_count), .last_count(last_count),
        .timeout_flag(timeout_flag));

    always #5 clk = ~clk;

    // responder: done arrives 'delay' cycles after the start pulse; corrupt adds 1 to the sum
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 0;
            adder_done <= 0;
        end else begin
            adder_done <= 0;
            if (adder_start && respond) begin
                if (delay == 1) begin
                    adder_done <= 1;
                    adder_sum <= a_out + b_out + {31'b0, corrupt};
                    adder_count <= cnt_val;
                end else begin
                    pending <= 1;
                    cnt <= delay - 2;
                end
            end else if (pending) begin
                if (cnt == 0) begin
                    pending <= 0;
                    adder_done <= 1;
                    adder_sum <= a_out + b_out + {31'b0, corrupt};
                    adder_count <= cnt_val;
                end else cnt <= cnt - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_batch(input int i);
        int iv;
        seed = v[i].seed;
        num_runs = v[i].n;
        delay = v[i].delay;
        respond = v[i].resp;
        nstarts = 0;
        imin = 1000000;
        imax = 0;
        corrupt = 0;
        @(negedge clk) go = 1;
        @(negedge clk) go = 0;
        for (cyc = 0; cyc < 5000 && !batch_done; cyc++) begin
            if (adder_start) begin
                nstarts++;
                if (nstarts == 1) begin
                    fa = a_out;
                    fb = b_out;
                end else begin
                    iv = cyc - last_t;
                    if (iv < imin) imin = iv;
                    if (iv > imax) imax = iv;
                end
                last_t = cyc;
                corrupt = nstarts == v[i].bad;
            end
            @(negedge clk);
        end
        chk($sformatf("v%0d batch_done", i), 32'(batch_done), 1);
        chk($sformatf("v%0d busy", i), 32'(busy), 0);
        chk($sformatf("v%0d run_count", i), 32'(run_count), 32'(v[i].er));
        chk($sformatf("v%0d err_count", i), 32'(err_count), 32'(v[i].ee));
        chk($sformatf("v%0d timeout_flag", i), 32'(timeout_flag), 32'(v[i].et));
        chk($sformatf("v%0d starts", i), 32'(nstarts), 32'(v[i].er));
        chk($sformatf("v%0d first a", i), fa, v[i].ea);
        chk($sformatf("v%0d first b", i), fb, v[i].eb);
        if (v[i].er > 1) begin
            iv = (!v[i].resp || v[i].delay >= 16) ? 20 : v[i].delay + 4;
            chk($sformatf("v%0d min interval", i), 32'(imin), 32'(iv));
            chk($sformatf("v%0d max interval", i), 32'(imax), 32'(iv));
        end
    endtask

    initial begin
        //        seed           n  dly resp bad run err to  a              b
        v[0] = '{32'h1,          1, 3,  1,   0,  1,  0,  0, 32'h00000001, 32'h80200003};
        v[1] = '{32'h0,          1, 1,  1,   0,  1,  0,  0, 32'h00000001, 32'h80200003};
        v[2] = '{32'h1,          4, 2,  1,   3,  4,  1,  0, 32'h00000001, 32'h80200003};
        v[3] = '{32'h1,          2, 1,  0,   0,  2,  2,  1, 32'h00000001, 32'h80200003};
        v[4] = '{32'h1,          0, 16, 1,   0,  1,  0,  0, 32'h00000001, 32'h80200003};
        v[5] = '{32'hC0300002,   2, 17, 1,   0,  2,  2,  1, 32'hC0300002, 32'h60180001};
        v[6] = '{32'h6C1B0001,   3, 5,  1,   1,  3,  1,  0, 32'h6C1B0001, 32'hB62D8003};

        repeat (3) @(negedge clk);
        chk("reset a_out", a_out, 0);
        chk("reset b_out", b_out, 0);
        chk("reset run_count", 32'(run_count), 0);
        chk("reset err_count", 32'(err_count), 0);
        chk("reset last_count", last_count, 0);
        chk("reset flags", {28'b0, adder_start, busy, batch_done, timeout_flag}, 0);
        rst = 0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_batch(i);

        cnt_val = 32'h12345678;
        delay = 3;
        respond = 1;
        corrupt = 0;
        num_runs = 1;
        @(negedge clk) go = 1;
        @(negedge clk) go = 0;
        for (cyc = 0; cyc < 50 && !adder_done; cyc++) @(negedge clk);
        chk("lc done seen", 32'(adder_done), 1);
        @(negedge clk);
        chk("lc last_count", last_count, 32'h12345678);
        for (cyc = 0; cyc < 50 && !batch_done; cyc++) @(negedge clk);
        chk("lc batch_done", 32'(batch_done), 1);

        delay = 10;
        @(negedge clk) go = 1;
        @(negedge clk) go = 0;
        for (cyc = 0; cyc < 50 && !adder_start; cyc++) @(negedge clk);
        chk("mid start seen", 32'(adder_start), 1);
        repeat (3) @(negedge clk);
        go = 1;
        rst = 1;
        @(negedge clk);
        chk("mid rst busy", 32'(busy), 0);
        chk("mid rst a_out", a_out, 0);
        chk("mid rst b_out", b_out, 0);
        chk("mid rst last_count", last_count, 0);
        rst = 0;
        nstarts = 0;
        repeat (40) begin
            @(negedge clk);
            if (adder_start || busy) nstarts++;
        end
        chk("held go no start", 32'(nstarts), 0);
        chk("held go idle", {29'b0, busy, batch_done, timeout_flag}, 0);
        go = 0;
        @(negedge clk);
        run_batch(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
